// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between the
// instruction-fetch (IF) and load (LD) requesters. Each requester gets a
// one-entry registered response, so read data arrives one cycle after the
// request handshake and at most one ROM access happens per cycle.
module rom_arbiter #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req_valid,
  input  logic [ADDR_BITS-1:0] if_req_addr,
  output logic                 if_req_ready,
  output logic                 if_resp_valid,
  output logic [DATA_BITS-1:0] if_resp_data,
  output logic                 if_resp_err,
  input  logic                 if_resp_ready,
  input  logic                 ld_req_valid,
  input  logic [ADDR_BITS-1:0] ld_req_addr,
  output logic                 ld_req_ready,
  output logic                 ld_resp_valid,
  output logic [DATA_BITS-1:0] ld_resp_data,
  output logic                 ld_resp_err,
  input  logic                 ld_resp_ready,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_BITS-1:0] rom_data
);

  // Port index 0 is IF, index 1 is LD.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_t;

  logic [1:0]           req_valid;
  logic [ADDR_BITS-1:0] req_addr [2];
  logic [1:0]           resp_ready;
  logic [1:0]           eligible;
  logic [1:0]           grant;

  logic [1:0]           resp_valid_reg;
  logic [DATA_BITS-1:0] resp_data_reg [2];
  logic [1:0]           resp_err_reg;
  port_t                last_grant_reg;

  assign req_valid   = {ld_req_valid, if_req_valid};
  assign req_addr[0] = if_req_addr;
  assign req_addr[1] = ld_req_addr;
  assign resp_ready  = {ld_resp_ready, if_resp_ready};

  // A port may be granted when its response slot is empty or is being
  // drained in this same cycle, which lets a port stream back-to-back.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign eligible[gi] = req_valid[gi] &&
                            (!resp_valid_reg[gi] || resp_ready[gi]);
    end
  endgenerate

  // Round-robin pick: under contention the port that did not win last time
  // is granted; nothing is granted while reset is asserted.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (eligible == 2'b11) begin
        grant = (last_grant_reg == PORT_LD) ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  // Drive the ROM from the winning port; park the address at zero when idle.
  always_comb begin
    rom_addr = '0;
    if (grant[0]) begin
      rom_addr = req_addr[0];
    end else if (grant[1]) begin
      rom_addr = req_addr[1];
    end
  end

  // Priority pointer only moves on an actual grant, so idle cycles keep it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= PORT_LD;
    end else if (grant[0]) begin
      last_grant_reg <= PORT_IF;
    end else if (grant[1]) begin
      last_grant_reg <= PORT_LD;
    end
  end

  // Per-port response register: load on grant, clear valid on drain, hold
  // data and error stable while the consumer back-pressures.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      always_ff @(posedge clk) begin
        if (reset) begin
          resp_valid_reg[gi] <= 1'b0;
          resp_data_reg[gi]  <= '0;
          resp_err_reg[gi]   <= 1'b0;
        end else if (grant[gi]) begin
          resp_valid_reg[gi] <= 1'b1;
          resp_data_reg[gi]  <= rom_data;
          resp_err_reg[gi]   <= (req_addr[gi][1:0] != 2'b00);
        end else if (resp_valid_reg[gi] && resp_ready[gi]) begin
          resp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign if_req_ready  = grant[0];
  assign ld_req_ready  = grant[1];
  assign if_resp_valid = resp_valid_reg[0];
  assign if_resp_data  = resp_data_reg[0];
  assign if_resp_err   = resp_err_reg[0];
  assign ld_resp_valid = resp_valid_reg[1];
  assign ld_resp_data  = resp_data_reg[1];
  assign ld_resp_err   = resp_err_reg[1];

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: the stimulus process predicts grants
// from the arbitration rules and queues the expected responses, and an
// independent monitor pops and compares them as responses are consumed.
module tb_rom_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req_valid = 1'b0;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_req_ready;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_data;
  logic          if_resp_err;
  logic          if_resp_ready = 1'b0;
  logic          ld_req_valid = 1'b0;
  logic [AW-1:0] ld_req_addr = '0;
  logic          ld_req_ready;
  logic          ld_resp_valid;
  logic [DW-1:0] ld_resp_data;
  logic          ld_resp_err;
  logic          ld_resp_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  logic [DW-1:0] rom_mem [256];
  assign rom_data = rom_mem[rom_addr[AW-1:2]];

  rom_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .if_resp_ready(if_resp_ready),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_err(ld_resp_err),
    .ld_resp_ready(ld_resp_ready),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  int    n_compared = 0;
  int    n_mismatched = 0;
  resp_t q_if[$];
  resp_t q_ld[$];
  bit    model_last_is_ld = 1'b1;  // IF wins first contention after reset
  bit    g_if, g_ld;
  bit    prev_rst = 1'b0;
  bit    monitor_en = 1'b0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: one cycle's response check, 1 time unit after inputs change.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (monitor_en) begin
        chk("if_resp_valid", {31'd0, if_resp_valid}, {31'd0, q_if.size() != 0});
        if (q_if.size() != 0) begin
          chk("if_resp_data", if_resp_data, q_if[0].data);
          chk("if_resp_err", {31'd0, if_resp_err}, {31'd0, q_if[0].err});
          if (if_resp_ready) void'(q_if.pop_front());
        end
        chk("ld_resp_valid", {31'd0, ld_resp_valid}, {31'd0, q_ld.size() != 0});
        if (q_ld.size() != 0) begin
          chk("ld_resp_data", ld_resp_data, q_ld[0].data);
          chk("ld_resp_err", {31'd0, ld_resp_err}, {31'd0, q_ld[0].err});
          if (ld_resp_ready) void'(q_ld.pop_front());
        end
      end
    end
  end

  // One clock of stimulus plus grant prediction; runs after the monitor.
  task automatic cyc(input bit rst, input bit ifv, input logic [AW-1:0] ifa, input bit ifr,
                     input bit ldv, input logic [AW-1:0] lda, input bit ldr);
    bit e_if, e_ld;
    logic [AW-1:0] exp_addr;
    resp_t r;
    @(negedge clk);
    reset = rst;
    if_req_valid = ifv; if_req_addr = ifa; if_resp_ready = ifr;
    ld_req_valid = ldv; ld_req_addr = lda; ld_resp_ready = ldr;
    #2;
    if (prev_rst && monitor_en) begin
      chk("if_resp_data_after_reset", if_resp_data, '0);
      chk("ld_resp_data_after_reset", ld_resp_data, '0);
      chk("if_resp_err_after_reset", {31'd0, if_resp_err}, 32'd0);
      chk("ld_resp_err_after_reset", {31'd0, ld_resp_err}, 32'd0);
    end
    g_if = 1'b0; g_ld = 1'b0;
    if (!rst) begin
      // Monitor already drained any consumed entry this cycle.
      e_if = ifv && (q_if.size() == 0);
      e_ld = ldv && (q_ld.size() == 0);
      if (e_if && e_ld) begin
        g_if = model_last_is_ld;
        g_ld = !model_last_is_ld;
      end else begin
        g_if = e_if;
        g_ld = e_ld;
      end
    end
    exp_addr = g_if ? ifa : (g_ld ? lda : '0);
    chk("if_req_ready", {31'd0, if_req_ready}, {31'd0, g_if});
    chk("ld_req_ready", {31'd0, ld_req_ready}, {31'd0, g_ld});
    chk("rom_addr", {22'd0, rom_addr}, {22'd0, exp_addr});
    $display("cycle t=%0t rst=%0b if(v=%0b a=%03h rdy=%0b) ld(v=%0b a=%03h rdy=%0b) grant if=%0b ld=%0b",
             $time, rst, ifv, ifa, ifr, ldv, lda, ldr, g_if, g_ld);
    if (rst) begin
      q_if.delete();
      q_ld.delete();
      model_last_is_ld = 1'b1;
    end else if (g_if) begin
      r.data = rom_mem[ifa[AW-1:2]];
      r.err  = (ifa[1:0] != 2'b00);
      q_if.push_back(r);
      model_last_is_ld = 1'b0;
    end else if (g_ld) begin
      r.data = rom_mem[lda[AW-1:2]];
      r.err  = (lda[1:0] != 2'b00);
      q_ld.push_back(r);
      model_last_is_ld = 1'b1;
    end
    prev_rst = rst;
    monitor_en = 1'b1;
  endtask

  initial begin
    bit            if_hold, ld_hold;
    bit            ifv, ldv, rst;
    logic [AW-1:0] ifa, lda;
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h00000093;
    rom_mem[1] = 32'h00500113;
    rom_mem[2] = 32'h00a00193;

    // Reset
    cyc(1, 0, '0, 0, 0, '0, 0);
    cyc(1, 0, '0, 0, 0, '0, 0);

    // IF only
    cyc(0, 1, 10'h004, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    // Contention right after reset: IF, LD, IF, LD ...
    cyc(1, 0, '0, 1, 0, '0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 10'h010, 1, 1, 10'h020, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    // Backpressure on IF while LD keeps streaming
    cyc(0, 1, 10'h008, 1, 0, '0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 10'h00c, 0, 1, 10'h030, 1);
    cyc(0, 1, 10'h00c, 1, 1, 10'h030, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    // Misaligned LD
    cyc(0, 0, '0, 1, 1, 10'h006, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    // IF streaming without bubbles
    cyc(0, 1, 10'h000, 1, 0, '0, 1);
    cyc(0, 1, 10'h004, 1, 0, '0, 1);
    cyc(0, 1, 10'h008, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    // Reset with an LD response pending, then IF first under contention
    cyc(0, 0, '0, 1, 1, 10'h010, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(1, 0, '0, 1, 0, '0, 0);
    cyc(0, 1, 10'h014, 1, 1, 10'h018, 1);
    cyc(0, 0, '0, 1, 1, 10'h018, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    // Randomized traffic; unaccepted requests are held stable
    if_hold = 1'b0; ld_hold = 1'b0;
    ifa = '0; lda = '0;
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!if_hold) begin
        ifv = ($urandom_range(0, 3) != 0);
        ifa = AW'($urandom);
      end
      if (!ld_hold) begin
        ldv = ($urandom_range(0, 2) != 0);
        lda = AW'($urandom);
      end
      cyc(rst, ifv, ifa, ($urandom_range(0, 2) != 0), ldv, lda, ($urandom_range(0, 2) != 0));
      if_hold = ifv && !g_if && !rst;
      ld_hold = ldv && !g_ld && !rst;
    end
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
